// File: rtl/eip_redirect_unit.sv
// EIP register with writeback redirect and a wrong-path flush window.
// Define EIP_REDIRECT_CNT_EN to build the saturating taken-redirect counter.
module eip_redirect_unit #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned NSRC         = 2,
  parameter int unsigned NFLAG        = 2,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_EIP    = 32'hFFF0,
  localparam int unsigned SELW        = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    de_valid,
  input  logic                    fe_not_stall,
  input  logic [WIDTH-1:0]        de_eip_next,
  input  logic                    wb_valid,
  input  logic                    wb_eip_change,
  input  logic [NSRC*WIDTH-1:0]   wb_res,
  input  logic [SELW-1:0]         wb_res_sel,
  input  logic                    wb_pr_size_over,
  input  logic [NFLAG-1:0]        wb_cond_en,
  input  logic [NFLAG-1:0]        wb_flag_expected,
  input  logic [NFLAG-1:0]        wb_flag,
  output logic [WIDTH-1:0]        eip,
  output logic                    redirect,
  output logic                    flush_busy,
  output logic [31:0]             redirect_cnt
);

  localparam int unsigned FCW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // A disabled flag always passes; an enabled one must match its expected value.
  function automatic logic cond_met(input logic [NFLAG-1:0] en,
                                    input logic [NFLAG-1:0] expv,
                                    input logic [NFLAG-1:0] flg);
    return &(~en | ~(flg ^ expv));
  endfunction

  state_e           state_q;
  logic [FCW-1:0]   fcnt_q;
  logic             redirect_q;
  logic [WIDTH-1:0] eip_q;
  logic [WIDTH-1:0] eip_d;
  logic [WIDTH-1:0] tgt_raw_s;
  logic [WIDTH-1:0] tgt_s;
  logic             take_s;
  logic             seq_s;

  assign flush_busy = (state_q == ST_FLUSH);
  assign eip        = eip_q;
  assign redirect   = redirect_q;

  // Target selection, redirect decision and next-EIP priority
  always_comb begin
    tgt_raw_s = wb_res[WIDTH-1:0];
    for (int unsigned i = 0; i < NSRC; i++) begin
      tgt_raw_s = (32'(wb_res_sel) == i) ? wb_res[i*WIDTH +: WIDTH] : tgt_raw_s;
    end
    tgt_s  = wb_pr_size_over ? {{(WIDTH-16){1'b0}}, tgt_raw_s[15:0]} : tgt_raw_s;
    take_s = wb_valid & wb_eip_change & cond_met(wb_cond_en, wb_flag_expected, wb_flag);
    seq_s  = de_valid & fe_not_stall & ~flush_busy;
    if (take_s) begin
      eip_d = tgt_s;
    end else if (seq_s) begin
      eip_d = de_eip_next;
    end else begin
      eip_d = eip_q;
    end
  end

  // Flush-window FSM with EIP and redirect pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fcnt_q     <= '0;
      redirect_q <= 1'b0;
      eip_q      <= WIDTH'(RESET_EIP);
    end else begin
      eip_q <= eip_d;
      case (state_q)
        ST_IDLE: begin
          if (take_s) begin
            state_q    <= ST_FLUSH;
            fcnt_q     <= FCW'(FLUSH_CYCLES - 1);
            redirect_q <= 1'b1;
          end else begin
            redirect_q <= 1'b0;
          end
        end
        ST_FLUSH: begin
          // A new redirect restarts the window from the top.
          if (take_s) begin
            fcnt_q     <= FCW'(FLUSH_CYCLES - 1);
            redirect_q <= 1'b1;
          end else if (fcnt_q == '0) begin
            state_q    <= ST_IDLE;
            redirect_q <= 1'b0;
          end else begin
            fcnt_q     <= fcnt_q - FCW'(1);
            redirect_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          fcnt_q     <= '0;
          redirect_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef EIP_REDIRECT_CNT_EN
  logic [31:0] cnt_q;

  // Saturating count of taken redirects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 32'd0;
    end else if (take_s && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign redirect_cnt = cnt_q;
`else
  assign redirect_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_eip_redirect_unit.sv
// Self-checking bench for eip_redirect_unit: directed vector table, async reset
// sequence and randomized stimulus against a behavioural model.
module tb_eip_redirect_unit;

  localparam int FC = 2;

  logic        clk;
  logic        rst;
  logic        de_valid, fe_not_stall, wb_valid, wb_eip_change, wb_pr_size_over;
  logic [31:0] de_eip_next, res0, res1;
  logic        wb_res_sel;
  logic [1:0]  wb_cond_en, wb_flag_expected, wb_flag;
  logic [31:0] eip, redirect_cnt;
  logic        redirect, flush_busy;

  int n_chk;
  int n_err;

  // model state
  logic [31:0] m_eip, m_cnt;
  logic        m_red, m_has_take;
  int          m_edge, m_last_take;

  eip_redirect_unit #(
    .WIDTH(32), .NSRC(2), .NFLAG(2), .FLUSH_CYCLES(FC), .RESET_EIP(32'hFFF0)
  ) dut (
    .clk(clk), .rst(rst),
    .de_valid(de_valid), .fe_not_stall(fe_not_stall), .de_eip_next(de_eip_next),
    .wb_valid(wb_valid), .wb_eip_change(wb_eip_change), .wb_res({res1, res0}),
    .wb_res_sel(wb_res_sel), .wb_pr_size_over(wb_pr_size_over),
    .wb_cond_en(wb_cond_en), .wb_flag_expected(wb_flag_expected), .wb_flag(wb_flag),
    .eip(eip), .redirect(redirect), .flush_busy(flush_busy), .redirect_cnt(redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dv, fns;
    logic [31:0] dn;
    logic        wv, wc;
    logic [31:0] r0, r1;
    logic        sel, pso;
    logic [1:0]  ce, fe, fl;
    logic [31:0] e_eip;
    logic        e_red, e_busy;
    logic [31:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic dv, fns, input logic [31:0] dn,
                              input logic wv, wc, input logic [31:0] r0, r1,
                              input logic sel, pso, input logic [1:0] ce, fe, fl,
                              input logic [31:0] e_eip, input logic e_red, e_busy,
                              input logic [31:0] e_cnt);
    vec_t v;
    v.dv = dv; v.fns = fns; v.dn = dn; v.wv = wv; v.wc = wc; v.r0 = r0; v.r1 = r1;
    v.sel = sel; v.pso = pso; v.ce = ce; v.fe = fe; v.fl = fl;
    v.e_eip = e_eip; v.e_red = e_red; v.e_busy = e_busy; v.e_cnt = e_cnt;
    return v;
  endfunction

  function automatic logic [31:0] cnt_exp(input logic [31:0] c);
`ifdef EIP_REDIRECT_CNT_EN
    return c;
`else
    return 32'd0 & c;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_eip = 32'h0000_FFF0; m_cnt = 32'd0; m_red = 1'b0;
    m_has_take = 1'b0; m_edge = 0; m_last_take = 0;
  endtask

  // Advance the model by one clock using the current inputs, then step the DUT.
  task automatic apply_edge();
    logic        busy_before, cm, take;
    logic [31:0] t;
    busy_before = m_has_take && ((m_edge - m_last_take) < FC);
    cm = 1'b1;
    for (int i = 0; i < 2; i++)
      if (wb_cond_en[i] && (wb_flag[i] != wb_flag_expected[i])) cm = 1'b0;
    take = wb_valid && wb_eip_change && cm;
    t = wb_res_sel ? res1 : res0;
    if (wb_pr_size_over) t = t % 32'h1_0000;
    m_edge++;
    if (take) begin
      m_eip = t; m_has_take = 1'b1; m_last_take = m_edge;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end else if (de_valid && fe_not_stall && !busy_before) begin
      m_eip = de_eip_next;
    end
    m_red = take;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    de_valid = v.dv; fe_not_stall = v.fns; de_eip_next = v.dn;
    wb_valid = v.wv; wb_eip_change = v.wc; res0 = v.r0; res1 = v.r1;
    wb_res_sel = v.sel; wb_pr_size_over = v.pso;
    wb_cond_en = v.ce; wb_flag_expected = v.fe; wb_flag = v.fl;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".eip"}, eip, m_eip);
    chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, m_red});
    chk({tag, ".flush_busy"}, {31'd0, flush_busy},
        {31'd0, m_has_take && ((m_edge - m_last_take) < FC)});
    chk({tag, ".cnt"}, redirect_cnt, cnt_exp(m_cnt));
  endtask

  vec_t vt[15];

  initial begin
    n_chk = 0; n_err = 0;
    // dv fns dn wv wc r0 r1 sel pso ce fe fl | eip red busy cnt
    vt[0]  = mk(1,1,32'h1004, 0,0, 32'h0,        32'h0,    0,0, 2'b00,2'b00,2'b00, 32'h1004, 0,0, 0);
    vt[1]  = mk(1,1,32'h1008, 1,1, 32'h0,        32'h2000, 1,0, 2'b01,2'b01,2'b01, 32'h2000, 1,1, 1);
    vt[2]  = mk(1,1,32'h1008, 0,0, 32'h0,        32'h0,    0,0, 2'b00,2'b00,2'b00, 32'h2000, 0,1, 1);
    vt[3]  = mk(1,1,32'h1008, 0,0, 32'h0,        32'h0,    0,0, 2'b00,2'b00,2'b00, 32'h2000, 0,0, 1);
    vt[4]  = mk(1,1,32'h1008, 0,0, 32'h0,        32'h0,    0,0, 2'b00,2'b00,2'b00, 32'h1008, 0,0, 1);
    vt[5]  = mk(1,1,32'h100C, 1,1, 32'h0,        32'h2000, 1,0, 2'b01,2'b01,2'b00, 32'h100C, 0,0, 1);
    vt[6]  = mk(0,1,32'h0,    1,1, 32'h1234ABCD, 32'h0,    0,1, 2'b00,2'b00,2'b00, 32'hABCD, 1,1, 2);
    vt[7]  = mk(0,1,32'h0,    0,0, 32'h0,        32'h0,    0,0, 2'b00,2'b00,2'b00, 32'hABCD, 0,1, 2);
    vt[8]  = mk(0,1,32'h0,    0,0, 32'h0,        32'h0,    0,0, 2'b00,2'b00,2'b00, 32'hABCD, 0,0, 2);
    vt[9]  = mk(0,1,32'h0,    1,1, 32'h3000,     32'h0,    0,0, 2'b00,2'b00,2'b00, 32'h3000, 1,1, 3);
    vt[10] = mk(0,1,32'h0,    1,1, 32'h4000,     32'h0,    0,0, 2'b00,2'b00,2'b00, 32'h4000, 1,1, 4);
    vt[11] = mk(0,1,32'h0,    0,0, 32'h0,        32'h0,    0,0, 2'b00,2'b00,2'b00, 32'h4000, 0,1, 4);
    vt[12] = mk(0,1,32'h0,    0,0, 32'h0,        32'h0,    0,0, 2'b00,2'b00,2'b00, 32'h4000, 0,0, 4);
    vt[13] = mk(1,0,32'h5000, 0,0, 32'h0,        32'h0,    0,0, 2'b00,2'b00,2'b00, 32'h4000, 0,0, 4);
    vt[14] = mk(1,1,32'h5000, 1,1, 32'h0,        32'h6000, 1,0, 2'b11,2'b10,2'b10, 32'h6000, 1,1, 5);

    rst = 1'b1;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.eip", eip, 32'h0000_FFF0);
    chk("reset.redirect", {31'd0, redirect}, 32'd0);
    chk("reset.flush_busy", {31'd0, flush_busy}, 32'd0);
    chk("reset.cnt", redirect_cnt, 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 15; k++) begin
      drive(vt[k]);
      apply_edge();
      chk($sformatf("vec%0d.eip", k), eip, vt[k].e_eip);
      chk($sformatf("vec%0d.redirect", k), {31'd0, redirect}, {31'd0, vt[k].e_red});
      chk($sformatf("vec%0d.flush_busy", k), {31'd0, flush_busy}, {31'd0, vt[k].e_busy});
      chk($sformatf("vec%0d.cnt", k), redirect_cnt, cnt_exp(vt[k].e_cnt));
    end

    // Async reset in the middle of a flush window
    drive(mk(0,1,0, 1,1, 32'h7000,0, 0,0, 2'b00,2'b00,2'b00, 0,0,0,0));
    apply_edge();
    drive(mk(1,1,32'h8000, 0,0, 0,0, 0,0, 2'b00,2'b00,2'b00, 0,0,0,0));
    chk("arst.pre_busy", {31'd0, flush_busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst.eip", eip, 32'h0000_FFF0);
    chk("arst.flush_busy", {31'd0, flush_busy}, 32'd0);
    chk("arst.redirect", {31'd0, redirect}, 32'd0);
    chk("arst.cnt", redirect_cnt, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    apply_edge();
    chk("arst.seq_after", eip, 32'h8000);
    check_model("arst.model");

    // Randomized stimulus against the model
    for (int n = 0; n < 400; n++) begin
      de_valid         = ($urandom_range(0, 4) != 0);
      fe_not_stall     = ($urandom_range(0, 4) != 0);
      de_eip_next      = $urandom;
      wb_valid         = ($urandom_range(0, 2) == 0);
      wb_eip_change    = ($urandom_range(0, 3) != 0);
      res0             = $urandom;
      res1             = $urandom;
      wb_res_sel       = 1'($urandom);
      wb_pr_size_over  = ($urandom_range(0, 3) == 0);
      wb_cond_en       = 2'($urandom);
      wb_flag_expected = 2'($urandom);
      wb_flag          = 2'($urandom);
      apply_edge();
      check_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/eip_redirect_unit.md
# eip_redirect_unit

Parametrised EIP register with writeback redirect control, the successor to the two-source EIP register. It sits between decode and writeback and holds the architectural fetch pointer. It advances sequentially from decode, or redirects to a writeback ALU result when a control transfer's flag conditions are met. After a redirect it runs a flush-window state machine that blocks wrong-path sequential updates. It supports configurable pointer width, number of result sources and number of condition flags.

## Interface
Parameters:
- WIDTH, 32: EIP width in bits; must be at least 17.
- NSRC, 2: number of writeback result candidates for the redirect target.
- NFLAG, 2: number of condition flags checked, e.g. CF and ZF.
- FLUSH_CYCLES, 2: length of the wrong-path suppression window; must be at least 1.
- RESET_EIP, 32'hFFF0: EIP value loaded on reset, truncated to WIDTH.

Ports (SELW = max(1, clog2(NSRC))):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- de_valid  in  1  decode stage holds a valid instruction.
- fe_not_stall  in  1  fetch is not stalled.
- de_eip_next  in  WIDTH  sequential next EIP from decode.
- wb_valid  in  1  writeback stage valid.
- wb_eip_change  in  1  instruction in writeback modifies EIP.
- wb_res  in  NSRC*WIDTH  packed candidate targets; source i is in bits [i*WIDTH +: WIDTH].
- wb_res_sel  in  SELW  index of the target source; values ≥ NSRC select source 0.
- wb_pr_size_over  in  1  16-bit operand-size override; the target is truncated to 16 bits.
- wb_cond_en  in  NFLAG  per-flag condition check enable.
- wb_flag_expected  in  NFLAG  expected flag values.
- wb_flag  in  NFLAG  current flag values from writeback.
- eip  out  WIDTH  registered EIP.
- redirect  out  1  registered one-cycle pulse; high in the first cycle `eip` shows a redirect target.
- flush_busy  out  1  wrong-path suppression window is active.
- redirect_cnt  out  32  count of taken redirects (see Configuration).

## Operation
- cond_met = AND over all i of (~wb_cond_en[i] | (wb_flag[i] XNOR wb_flag_expected[i])).
- take = wb_valid & wb_eip_change & cond_met.
- tgt = wb_res source selected by wb_res_sel.
- If wb_pr_size_over is set: tgt = {(WIDTH-16)'b0, tgt[15:0]}.
- seq = de_valid & fe_not_stall & ~flush_busy.
- EIP update priority:
  - take: eip ← tgt.
  - else seq: eip ← de_eip_next.
  - else: hold.
- State machine, states IDLE and FLUSH, with down-counter fcnt of width clog2(FLUSH_CYCLES+1):
  - IDLE, take: go to FLUSH, fcnt ← FLUSH_CYCLES-1, redirect ← 1.
  - IDLE, no take: stay in IDLE, redirect ← 0.
  - FLUSH, take: stay in FLUSH, fcnt ← FLUSH_CYCLES-1, redirect ← 1. A new redirect restarts the window.
  - FLUSH, fcnt == 0 and no take: go to IDLE.
  - FLUSH, otherwise: fcnt ← fcnt-1, redirect ← 0.
- flush_busy = (state == FLUSH), taken directly from the state register.
- The flush window blocks sequential updates only; a redirect is always accepted.

## Timing
- Reset, asynchronous and active-high, effective immediately:
  - eip = RESET_EIP, redirect = 0, flush_busy = 0.
  - state = IDLE, fcnt = 0, redirect_cnt = 0.
- Reset asserted mid-FLUSH aborts the window; the first cycle after reset release is IDLE.
- A take sampled at edge N gives, from edge N onward: eip = tgt, redirect = 1 for one cycle, flush_busy = 1.
- flush_busy stays high for exactly FLUSH_CYCLES cycles after the last take.
- Sequential loads are blocked during the window and first take effect the cycle flush_busy is low.
- A take and seq in the same cycle load the target; the decode value is dropped.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro EIP_REDIRECT_CNT_EN.
- Defined: redirect_cnt is a 32-bit counter.
  - Increments at each edge where take = 1.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rst.
- Undefined: the counter is not built and redirect_cnt is tied to 0. The port list is unchanged.

## Test plan
- Reset and sequential advance: hold rst, then release with WIDTH=32. Expect eip=0000_FFF0. Then set de_valid=1, fe_not_stall=1, de_eip_next=0000_1004. Expect eip=0000_1004 one edge later, redirect=0.
- Conditional redirect, condition met: wb_valid=1, wb_eip_change=1, wb_cond_en=01, wb_flag_expected=01, wb_flag=01, wb_res_sel=1, source 1 = 0000_2000. Expect eip=0000_2000 and redirect=1 for one cycle. With FLUSH_CYCLES=2, expect flush_busy=1 for 2 cycles while de_eip_next=0000_1008 is ignored, then eip=0000_1008.
- Condition failed: same stimulus but wb_flag=00. Expect no redirect, eip follows decode, flush_busy=0, redirect_cnt unchanged.
- Operand-size truncation: take with source 0 = 1234_ABCD and wb_pr_size_over=1. Expect eip=0000_ABCD.
- Back-to-back redirects: take to 0000_3000, then take to 0000_4000 on the next cycle. Expect two redirect pulses, flush_busy high for FLUSH_CYCLES+1 cycles total. With EIP_REDIRECT_CNT_EN defined, expect redirect_cnt=2.
- Async reset mid-flush: assert rst between edges while flush_busy=1. Expect immediate eip=0000_FFF0, flush_busy=0, redirect=0, redirect_cnt=0.
